// File: rtl/sect233k1_pt_mul_arb.sv
// sect233k1_pt_mul_arb
// Shares one sect233k1 point-multiplication core between NumReq clients.
// Requests are granted round-robin. Each granted scalar is launched with a
// one-cycle start pulse. The core's done rising edge returns the result
// point to the owner. A watchdog aborts a hung operation and re-clears the
// core.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req / req_d       per-requester request level and flattened 233-bit scalars
//   gnt               one-hot grant pulse (req_d is latched on the cycle before)
//   rsp_vld / rsp_err one-hot response pulse; error flags a timeout abort
//   rsp_x / rsp_y     result coordinates, held until the next response
//   busy              high whenever the sequencer is not idle
//   pm_clr / pm_start core clear and start pulses
//   pm_d              scalar to the core, zero except while pm_start is high
//   pm_done, pm_x/y   core completion level and result
module sect233k1_pt_mul_arb #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumReq-1:0]     req,
  input  logic [NumReq*233-1:0] req_d,
  output logic [NumReq-1:0]     gnt,
  output logic [NumReq-1:0]     rsp_vld,
  output logic                  rsp_err,
  output logic [232:0]          rsp_x,
  output logic [232:0]          rsp_y,
  output logic                  busy,
  output logic                  pm_clr,
  output logic                  pm_start,
  output logic [232:0]          pm_d,
  input  logic                  pm_done,
  input  logic [232:0]          pm_x,
  input  logic [232:0]          pm_y
);

  localparam int DW   = 233;
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] ARM   = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]        state_r;
  logic [IdxW-1:0]   ptr_r;
  logic [IdxW-1:0]   owner_r;
  logic [CntW-1:0]   cnt_r;
  logic              done_q_r;
  logic [NumReq-1:0] gnt_r;
  logic [NumReq-1:0] rsp_vld_r;
  logic              rsp_err_r;
  logic [DW-1:0]     rsp_x_r;
  logic [DW-1:0]     rsp_y_r;
  logic              busy_r;
  logic              pm_clr_r;
  logic              pm_start_r;
  logic [DW-1:0]     pm_d_r;

  logic              sel_vld_s;
  logic [IdxW-1:0]   sel_s;
  logic [DW-1:0]     sel_d_s;
  logic              done_edge_s;
  logic [IdxW-1:0]   next_ptr_s;

  // (ptr + k) mod NumReq for 0 <= k < NumReq, without a divider.
  function automatic logic [IdxW-1:0] wrap_idx(input int s);
    int r;
    if (s >= NumReq) begin
      r = s - NumReq;
    end else begin
      r = s;
    end
    return IdxW'(r);
  endfunction

  function automatic logic [NumReq-1:0] onehot(input logic [IdxW-1:0] i);
    logic [NumReq-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    sel_vld_s = 1'b0;
    sel_s     = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(ptr_r) + k)]) begin
        sel_vld_s = 1'b1;
        sel_s     = wrap_idx(int'(ptr_r) + k);
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
  end

  // Scalar of the selected requester, completion edge and pointer successor.
  always_comb begin
    sel_d_s     = req_d[DW*int'(sel_s) +: DW];
    done_edge_s = pm_done & ~done_q_r;
    if (owner_r == IdxLast) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + IdxW'(1);
    end
  end

  // Sequencer FSM; all outputs are registered and pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= INIT;
      ptr_r      <= '0;
      owner_r    <= '0;
      cnt_r      <= '0;
      done_q_r   <= 1'b0;
      gnt_r      <= '0;
      rsp_vld_r  <= '0;
      rsp_err_r  <= 1'b0;
      rsp_x_r    <= '0;
      rsp_y_r    <= '0;
      busy_r     <= 1'b0;
      pm_clr_r   <= 1'b0;
      pm_start_r <= 1'b0;
      pm_d_r     <= '0;
    end else begin
      done_q_r   <= pm_done;
      gnt_r      <= '0;
      rsp_vld_r  <= '0;
      pm_clr_r   <= 1'b0;
      pm_start_r <= 1'b0;
      pm_d_r     <= '0;
      case (state_r)
        INIT: begin
          // First INIT cycle raises clr; the cycle showing clr moves on to IDLE.
          if (pm_clr_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            pm_clr_r <= 1'b1;
            busy_r   <= 1'b1;
          end
        end
        IDLE: begin
          if (sel_vld_s) begin
            owner_r    <= sel_s;
            gnt_r      <= onehot(sel_s);
            pm_start_r <= 1'b1;
            pm_d_r     <= sel_d_s;
            busy_r     <= 1'b1;
            state_r    <= START;
          end else begin
            busy_r <= 1'b0;
          end
        end
        START: begin
          cnt_r   <= '0;
          state_r <= ARM;
        end
        ARM: begin
          // pm_done may still carry the previous operation's level here.
          state_r <= WAIT;
        end
        WAIT: begin
          // A completion edge on the last counted cycle takes priority over the abort.
          if (done_edge_s) begin
            rsp_x_r   <= pm_x;
            rsp_y_r   <= pm_y;
            rsp_err_r <= 1'b0;
            rsp_vld_r <= onehot(owner_r);
            state_r   <= RESP;
          end else if (cnt_r == CntLast) begin
            rsp_x_r   <= '0;
            rsp_y_r   <= '0;
            rsp_err_r <= 1'b1;
            rsp_vld_r <= onehot(owner_r);
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + CntW'(1);
          end
        end
        RESP: begin
          ptr_r <= next_ptr_s;
          if (rsp_err_r) begin
            pm_clr_r <= 1'b1;
            state_r  <= INIT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b1;
          state_r <= INIT;
        end
      endcase
    end
  end

  assign gnt      = gnt_r;
  assign rsp_vld  = rsp_vld_r;
  assign rsp_err  = rsp_err_r;
  assign rsp_x    = rsp_x_r;
  assign rsp_y    = rsp_y_r;
  assign busy     = busy_r;
  assign pm_clr   = pm_clr_r;
  assign pm_start = pm_start_r;
  assign pm_d     = pm_d_r;

endmodule

// File: tb/tb_sect233k1_pt_mul_arb.sv
// Testbench for sect233k1_pt_mul_arb with a behavioral point-multiplier model.
// The model returns entries from a fixed reference table. It keeps done high
// for two cycles after a new start, which presents a stale level in ARM and in
// the first WAIT cycle. Expected grants and responses are queued as stimulus is
// issued, and a negedge monitor pops and compares them.
module tb_sect233k1_pt_mul_arb;

  localparam int NR = 4;
  localparam int TC = 16;
  localparam int W  = 233;

  localparam logic [W-1:0] GX = 233'h17232BA853A7E731AF129F22FF4149563A419C26BF50A4C9D6EEFAD6126;
  localparam logic [W-1:0] GY = 233'h1DB537DECE819B7F70F555A67C427A8CD9BF18AEB9B56E0C11056FAE6A3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] req_d = '0;
  logic [NR-1:0]   gnt, rsp_vld;
  logic            rsp_err, busy, pm_clr, pm_start;
  logic [W-1:0]    rsp_x, rsp_y, pm_d;

  // core model state
  logic            m_done;
  logic [W-1:0]    m_x, m_y, m_d;
  int              m_cnt;
  bit              m_active;
  int              m_lat = 8;
  bit              m_hang = 1'b0;

  typedef struct { logic [NR-1:0] oh; logic [W-1:0] d; } gexp_t;
  typedef struct { logic [NR-1:0] oh; logic err; logic [W-1:0] x; logic [W-1:0] y; int delta; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0, errors = 0;
  int cyc = 0, gnt_cyc = 0;
  int gnt_seen = 0, rsp_seen = 0, clr_cnt = 0;
  logic [NR-1:0] prev_gnt = '0, prev_rsp = '0;
  logic          prev_clr = 1'b0, prev_start = 1'b0;
  logic [NR-1:0] keep = '0;

  sect233k1_pt_mul_arb #(.NumReq(NR), .TimeoutCycles(TC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_d(req_d),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy), .pm_clr(pm_clr), .pm_start(pm_start), .pm_d(pm_d),
    .pm_done(m_done), .pm_x(m_x), .pm_y(m_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_x(input logic [W-1:0] d);
    case (d)
      233'h1:  return GX;
      233'h2A: return 233'h1111_2222_3333;
      233'h3B: return 233'hA5A5_0000_FFFF;
      233'h4C: return 233'h0BAD_C0DE;
      233'h5D: return 233'h1_0000_0000_0000_0001;
      233'h6E: return 233'hC0FFEE;
      233'h8A: return 233'h3;
      default: return 233'h0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_y(input logic [W-1:0] d);
    case (d)
      233'h1:  return GY;
      233'h2A: return 233'h4444_5555;
      233'h3B: return 233'h5A5A_1234;
      233'h4C: return 233'hFEED_BEEF;
      233'h5D: return 233'h7777;
      233'h6E: return 233'hDECAF;
      233'h8A: return 233'h6;
      default: return 233'h0;
    endcase
  endfunction

  // Behavioral core: done stays high from the previous run until two cycles after start.
  always @(posedge clk) begin
    if (!rst_n || pm_clr) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_done   <= 1'b0;
    end else if (pm_start) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      m_d      <= pm_d;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2) m_done <= 1'b0;
      if (!m_hang && m_cnt == m_lat) begin
        m_done   <= 1'b1;
        m_x      <= ref_x(m_d);
        m_y      <= ref_y(m_d);
        m_active <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on every grant / response and checks pulse shapes.
  always @(negedge clk) begin
    gexp_t ge;
    rexp_t re;
    if (|gnt) begin
      gnt_seen++;
      gnt_cyc = cyc;
      if (gq.size() == 0) begin
        chk("gnt_unexpected", gnt, '0);
      end else begin
        ge = gq.pop_front();
        chk("gnt_onehot", gnt, ge.oh);
        chk("gnt_pm_start", pm_start, 1'b1);
        chk("gnt_pm_d", pm_d, ge.d);
      end
      chk("gnt_single_cycle", prev_gnt, '0);
    end
    if (!pm_start) chk("pm_d_zero_without_start", pm_d, '0);
    if (pm_start) chk("start_single_cycle", prev_start, 1'b0);
    if (|rsp_vld) begin
      rsp_seen++;
      if (rq.size() == 0) begin
        chk("rsp_unexpected", rsp_vld, '0);
      end else begin
        re = rq.pop_front();
        chk("rsp_onehot", rsp_vld, re.oh);
        chk("rsp_err", rsp_err, re.err);
        chk("rsp_x", rsp_x, re.x);
        chk("rsp_y", rsp_y, re.y);
        chk("rsp_latency", cyc - gnt_cyc, re.delta);
      end
      chk("rsp_single_cycle", prev_rsp, '0);
    end
    if (pm_clr) begin
      clr_cnt++;
      chk("clr_single_cycle", prev_clr, 1'b0);
    end
    prev_gnt   = gnt;
    prev_rsp   = rsp_vld;
    prev_clr   = pm_clr;
    prev_start = pm_start;
  end

  // One cycle; requesters drop req when granted unless asked to keep it once.
  task automatic tick();
    logic [NR-1:0] g;
    @(posedge clk);
    #1;
    g    = gnt;
    req  = req & ~(g & ~keep);
    keep = keep & ~g;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    req_d[W*i +: W] = d;
    req[i] = 1'b1;
  endtask

  task automatic push_op(input int i, input logic [W-1:0] d, input logic err, input int delta);
    gexp_t ge;
    rexp_t re;
    ge.oh = '0; ge.oh[i] = 1'b1; ge.d = d;
    gq.push_back(ge);
    re.oh = ge.oh; re.err = err;
    re.x = err ? '0 : ref_x(d);
    re.y = err ? '0 : ref_y(d);
    re.delta = delta;
    rq.push_back(re);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_seen < target && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_arrived", rsp_seen, target);
  endtask

  initial begin
    gexp_t ge;
    int r0, c0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, '0);
    chk("rst_rsp_vld", rsp_vld, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_x", rsp_x, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pm_clr", pm_clr, 1'b0);
    chk("rst_pm_start", pm_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_clr_high", pm_clr, 1'b1);
    chk("init_busy_high", busy, 1'b1);
    @(negedge clk);
    chk("idle_clr_low", pm_clr, 1'b0);
    chk("idle_busy_low", busy, 1'b0);
    tick();
    chk("clr_count_after_reset", clr_cnt, 1);

    // single request on requester 2 with scalar 1 -> generator G
    push_op(2, 233'h1, 1'b0, m_lat + 2);
    set_req(2, 233'h1);
    wait_rsp(1, 100);

    // reset in WAIT: requester 3 is granted, then aborted by rst_n without a response
    ge.oh = 4'b1000; ge.d = 233'h99;
    gq.push_back(ge);
    set_req(3, 233'h99);
    r0 = rsp_seen;
    c0 = clr_cnt;
    repeat (6) tick();
    chk("mid_wait_granted", gnt_seen, 2);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_rsp_after_reset", rsp_seen, r0);
    chk("clr_reissued", clr_cnt, c0 + 1);

    // round robin from ptr 0: requester 0 keeps its request once -> 0,1,2,3,0
    push_op(0, 233'h2A, 1'b0, m_lat + 2);
    push_op(1, 233'h3B, 1'b0, m_lat + 2);
    push_op(2, 233'h4C, 1'b0, m_lat + 2);
    push_op(3, 233'h5D, 1'b0, m_lat + 2);
    push_op(0, 233'h2A, 1'b0, m_lat + 2);
    keep = 4'b0001;
    set_req(0, 233'h2A);
    set_req(1, 233'h3B);
    set_req(2, 233'h4C);
    set_req(3, 233'h5D);
    wait_rsp(r0 + 5, 300);

    // done edge on the last watchdog cycle completes normally
    m_lat = TC;
    push_op(1, 233'h6E, 1'b0, TC + 2);
    set_req(1, 233'h6E);
    wait_rsp(r0 + 6, 100);

    // done edge one cycle too late -> timeout, then core re-clear
    m_lat = TC + 1;
    c0 = clr_cnt;
    push_op(2, 233'h4C, 1'b1, TC + 2);
    set_req(2, 233'h4C);
    wait_rsp(r0 + 7, 100);
    repeat (3) tick();
    chk("clr_after_late_timeout", clr_cnt, c0 + 1);

    // core that never finishes -> timeout, re-clear, then a normal operation
    m_lat = 8;
    m_hang = 1'b1;
    c0 = clr_cnt;
    push_op(3, 233'h5D, 1'b1, TC + 2);
    set_req(3, 233'h5D);
    wait_rsp(r0 + 8, 100);
    repeat (3) tick();
    chk("clr_after_hang_timeout", clr_cnt, c0 + 1);
    m_hang = 1'b0;
    push_op(0, 233'h8A, 1'b0, m_lat + 2);
    set_req(0, 233'h8A);
    wait_rsp(r0 + 9, 100);

    repeat (5) tick();
    chk("gnt_queue_empty", gq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    chk("busy_final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
